// File: rtl/pipo_pkg.sv
// Shared constants and helpers for the pipo_pipe register pipeline.
package pipo_pkg;

    localparam int DEF_DW    = 5;
    localparam int DEF_DEPTH = 4;

    // Number of bits needed to hold an occupancy count in the range 0..depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: a signed data register plus its valid bit.
// i_clear empties the stage and zeroes the data. Otherwise, when i_advance
// is set the stage either takes the upstream word or becomes empty. When
// i_advance is clear the stage holds its contents.
module pipe_stage
    import pipo_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_advance,
    input  logic                 i_in_valid,
    input  logic signed [DW-1:0] i_in_data,
    output logic                 o_valid,
    output logic signed [DW-1:0] o_data,
    output logic                 o_valid_nxt
);

    logic                 valid_d;
    logic                 valid_q;
    logic signed [DW-1:0] data_d;
    logic signed [DW-1:0] data_q;

    // Next-state selection: clear wins, then advance (load or drain), else hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (i_clear) begin
            valid_d = 1'b0;
            data_d  = {DW{1'b0}};
        end else if (i_advance) begin
            if (i_in_valid) begin
                valid_d = 1'b1;
                data_d  = i_in_data;
            end else begin
                // Data is left in place so o_data shows the last word held.
                valid_d = 1'b0;
            end
        end else begin
            valid_d = valid_q;
            data_d  = data_q;
        end
    end

    // Stage registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= {DW{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_data      = data_q;
    assign o_valid_nxt = valid_d;

endmodule

// File: rtl/pipo_pipe.sv
// Parallel-in/parallel-out valid/ready pipeline of DEPTH stages.
// The ready chain is combinational, so a full pipeline still runs at one
// word per cycle when downstream accepts. Bubbles collapse because any
// stage with an empty stage below it may move forward while the output
// is stalled.
module pipo_pipe
    import pipo_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flush,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic signed [DW-1:0]         i_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic signed [DW-1:0]         o_data,
    output logic [cnt_w(DEPTH)-1:0]      o_count
);

    localparam int CW = cnt_w(DEPTH);

    logic [DEPTH-1:0]     valid_s;
    logic [DEPTH-1:0]     valid_nxt_s;
    logic [DEPTH-1:0]     adv_s;
    logic [DEPTH-1:0]     in_valid_s;
    logic signed [DW-1:0] data_s    [DEPTH];
    logic signed [DW-1:0] in_data_s [DEPTH];
    logic                 adv_acc_s;
    logic [CW-1:0]        count_d;
    logic [CW-1:0]        count_q;

    // A stage can advance when it, or any stage after it, is empty, or when
    // downstream is ready. Walk from the output back toward the input.
    always_comb begin
        adv_acc_s = i_ready;
        adv_s     = {DEPTH{1'b0}};
        for (int k = DEPTH - 1; k >= 0; k--) begin
            adv_acc_s = adv_acc_s | ~valid_s[k];
            adv_s[k]  = adv_acc_s;
        end
    end

    // Each stage is fed from the stage before it; stage 0 from the input port.
    always_comb begin
        in_valid_s[0] = i_valid;
        in_data_s[0]  = i_data;
        for (int k = 1; k < DEPTH; k++) begin
            in_valid_s[k] = valid_s[k-1];
            in_data_s[k]  = data_s[k-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        pipe_stage #(
            .DW (DW)
        ) u_stage (
            .clk         (clk),
            .rst         (rst),
            .i_clear     (i_flush),
            .i_advance   (adv_s[g]),
            .i_in_valid  (in_valid_s[g]),
            .i_in_data   (in_data_s[g]),
            .o_valid     (valid_s[g]),
            .o_data      (data_s[g]),
            .o_valid_nxt (valid_nxt_s[g])
        );
    end

    // Occupancy after the coming edge: population count of next valid bits.
    always_comb begin
        count_d = {CW{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            count_d = count_d + CW'(valid_nxt_s[k]);
        end
    end

    // Registered occupancy count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign o_ready = adv_s[0];
    assign o_valid = valid_s[DEPTH-1];
    assign o_data  = data_s[DEPTH-1];
    assign o_count = count_q;

endmodule

// File: tb/tb_pipo_pipe.sv
// Bench for pipo_pipe: three instances (DEPTH 4, 1, 6) share stimulus.
// Per-instance scoreboards track accepted words and occupancy; directed
// tasks check the DEPTH=4 instance against hand-derived values.
module tb_pipo_pipe;

    logic              clk;
    logic              rst;
    logic              i_flush;
    logic              i_valid;
    logic              i_ready;
    logic signed [4:0] i_data;

    logic [2:0]        ov_a;
    logic [2:0]        ordy_a;
    logic signed [4:0] od_a  [3];
    logic [3:0]        cnt_a [3];
    logic [2:0]        cnt0;
    logic [0:0]        cnt1;
    logic [2:0]        cnt2;

    int checks;
    int failures;
    int emit_cnt [3];
    logic mon_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipo_pipe #(.DW(5), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(ordy_a[0]),
        .i_data(i_data), .o_valid(ov_a[0]), .i_ready(i_ready), .o_data(od_a[0]), .o_count(cnt0)
    );
    pipo_pipe #(.DW(5), .DEPTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(ordy_a[1]),
        .i_data(i_data), .o_valid(ov_a[1]), .i_ready(i_ready), .o_data(od_a[1]), .o_count(cnt1)
    );
    pipo_pipe #(.DW(5), .DEPTH(6)) u_dut6 (
        .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(ordy_a[2]),
        .i_data(i_data), .o_valid(ov_a[2]), .i_ready(i_ready), .o_data(od_a[2]), .o_count(cnt2)
    );

    assign cnt_a[0] = {1'b0, cnt0};
    assign cnt_a[1] = {3'b000, cnt1};
    assign cnt_a[2] = {1'b0, cnt2};

    // Scoreboards: push on accept, pop/compare on output handshake, check count.
    for (genvar g = 0; g < 3; g++) begin : g_mon
        logic signed [4:0] sb_q [$];
        always @(negedge clk) begin
            #2;
            if (mon_en) begin
                checks = checks + 1;
                if (cnt_a[g] !== 4'(sb_q.size())) begin
                    failures = failures + 1;
                    $display("FAIL sb_count[%0d] got %0d required %0d", g, cnt_a[g], sb_q.size());
                end
                if (!rst) begin
                    sb_q.delete();
                end else begin
                    if (ov_a[g] && i_ready) begin
                        checks = checks + 1;
                        emit_cnt[g] = emit_cnt[g] + 1;
                        if (sb_q.size() == 0) begin
                            failures = failures + 1;
                            $display("FAIL sb_spurious[%0d] got data %0d required no output", g, od_a[g]);
                        end else begin
                            if (od_a[g] !== sb_q[0]) begin
                                failures = failures + 1;
                                $display("FAIL sb_data[%0d] got %0d required %0d", g, od_a[g], sb_q[0]);
                            end
                            void'(sb_q.pop_front());
                        end
                    end
                    if (i_flush) begin
                        sb_q.delete();
                    end else if (i_valid && ordy_a[g]) begin
                        sb_q.push_back(i_data);
                    end
                end
            end
        end
    end

    task automatic drive(input logic r_n, input logic v, input logic signed [4:0] d,
                         input logic rdy, input logic f);
        @(negedge clk);
        rst = r_n; i_valid = v; i_data = d; i_ready = rdy; i_flush = f;
        #3;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 5'sd0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 5'sd9, 1'b1, 1'b0);
        mon_en = 1'b1;
        drive(1'b1, 1'b0, 5'sd0, 1'b1, 1'b0);
        for (int g = 0; g < 3; g++) begin
            checks = checks + 1;
            if (ov_a[g] !== 1'b0 || od_a[g] !== 5'sd0 || cnt_a[g] !== 4'd0 || ordy_a[g] !== 1'b1) begin
                failures = failures + 1;
                $display("FAIL reset[%0d] got v=%b d=%0d cnt=%0d rdy=%b required 0 0 0 1",
                         g, ov_a[g], od_a[g], cnt_a[g], ordy_a[g]);
            end
        end
    endtask

    task automatic test_stream();
        logic signed [4:0] vals [4];
        vals[0] = 5'b10000; vals[1] = 5'b11111; vals[2] = 5'b00000; vals[3] = 5'b01111;
        for (int n = 0; n < 9; n++) begin
            drive(1'b1, 1'(n < 4), vals[n & 3], 1'b1, 1'b0);
            checks = checks + 1;
            if (n >= 4 && n < 8) begin
                if (ov_a[0] !== 1'b1 || od_a[0] !== vals[n-4]) begin
                    failures = failures + 1;
                    $display("FAIL stream n=%0d got v=%b d=%0d required v=1 d=%0d", n, ov_a[0], od_a[0], vals[n-4]);
                end
            end else begin
                if (ov_a[0] !== 1'b0) begin
                    failures = failures + 1;
                    $display("FAIL stream n=%0d got v=%b required v=0", n, ov_a[0]);
                end
            end
        end
        drain(8);
    endtask

    task automatic test_stall();
        logic signed [4:0] vals [4];
        vals[0] = 5'sd3; vals[1] = -5'sd4; vals[2] = 5'sd6; vals[3] = -5'sd7;
        for (int m = 0; m < 4; m++) begin
            drive(1'b1, 1'b1, vals[m], 1'b0, 1'b0);
            checks = checks + 1;
            if (ordy_a[0] !== 1'b1) begin
                failures = failures + 1;
                $display("FAIL stall_fill m=%0d got rdy=%b required 1", m, ordy_a[0]);
            end
        end
        for (int s = 0; s < 2; s++) begin
            drive(1'b1, 1'b0, 5'sd0, 1'b0, 1'b0);
            checks = checks + 1;
            if (cnt_a[0] !== 4'd4 || ordy_a[0] !== 1'b0 || ov_a[0] !== 1'b1 || od_a[0] !== vals[0]) begin
                failures = failures + 1;
                $display("FAIL stall_hold s=%0d got cnt=%0d rdy=%b v=%b d=%0d required 4 0 1 %0d",
                         s, cnt_a[0], ordy_a[0], ov_a[0], od_a[0], vals[0]);
            end
        end
        for (int m = 0; m < 4; m++) begin
            drive(1'b1, 1'b0, 5'sd0, 1'b1, 1'b0);
            checks = checks + 1;
            if (ov_a[0] !== 1'b1 || od_a[0] !== vals[m] || ordy_a[0] !== 1'b1) begin
                failures = failures + 1;
                $display("FAIL stall_release m=%0d got v=%b d=%0d rdy=%b required 1 %0d 1",
                         m, ov_a[0], od_a[0], ordy_a[0], vals[m]);
            end
        end
        drive(1'b1, 1'b0, 5'sd0, 1'b1, 1'b0);
        checks = checks + 1;
        if (ov_a[0] !== 1'b0 || cnt_a[0] !== 4'd0) begin
            failures = failures + 1;
            $display("FAIL stall_empty got v=%b cnt=%0d required 0 0", ov_a[0], cnt_a[0]);
        end
        drain(8);
    endtask

    task automatic test_bubble();
        drive(1'b1, 1'b1, 5'sd7, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 5'sd0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 5'sd3, 1'b0, 1'b0);
        for (int s = 0; s < 3; s++) drive(1'b1, 1'b0, 5'sd0, 1'b0, 1'b0);
        checks = checks + 1;
        if (cnt_a[0] !== 4'd2 || ov_a[0] !== 1'b1 || od_a[0] !== 5'sd7) begin
            failures = failures + 1;
            $display("FAIL bubble_stall got cnt=%0d v=%b d=%0d required 2 1 7", cnt_a[0], ov_a[0], od_a[0]);
        end
        drive(1'b1, 1'b0, 5'sd0, 1'b1, 1'b0);
        checks = checks + 1;
        if (ov_a[0] !== 1'b1 || od_a[0] !== 5'sd7) begin
            failures = failures + 1;
            $display("FAIL bubble_out0 got v=%b d=%0d required 1 7", ov_a[0], od_a[0]);
        end
        drive(1'b1, 1'b0, 5'sd0, 1'b1, 1'b0);
        checks = checks + 1;
        if (ov_a[0] !== 1'b1 || od_a[0] !== 5'sd3) begin
            failures = failures + 1;
            $display("FAIL bubble_out1 got v=%b d=%0d required 1 3", ov_a[0], od_a[0]);
        end
        drain(8);
    endtask

    task automatic test_back_to_back();
        for (int m = 0; m < 4; m++) drive(1'b1, 1'b1, 5'(m + 1), 1'b0, 1'b0);
        for (int m = 0; m < 3; m++) begin
            drive(1'b1, 1'b1, 5'(10 + m), 1'b1, 1'b0);
            checks = checks + 1;
            if (ordy_a[0] !== 1'b1 || ov_a[0] !== 1'b1 || od_a[0] !== 5'(m + 1) || cnt_a[0] !== 4'd4) begin
                failures = failures + 1;
                $display("FAIL b2b m=%0d got rdy=%b v=%b d=%0d cnt=%0d required 1 1 %0d 4",
                         m, ordy_a[0], ov_a[0], od_a[0], cnt_a[0], m + 1);
            end
        end
        drive(1'b1, 1'b0, 5'sd0, 1'b0, 1'b0);
        checks = checks + 1;
        if (cnt_a[0] !== 4'd4 || od_a[0] !== 5'sd4) begin
            failures = failures + 1;
            $display("FAIL b2b_count got cnt=%0d d=%0d required 4 4", cnt_a[0], od_a[0]);
        end
        drain(8);
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b1, 5'sd1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 5'sd2, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 5'sd4, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 5'sd5, 1'b0, 1'b1);
        checks = checks + 1;
        if (ordy_a[0] !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL flush_rdy got %b required 1", ordy_a[0]);
        end
        drive(1'b1, 1'b0, 5'sd0, 1'b1, 1'b0);
        checks = checks + 1;
        if (ov_a[0] !== 1'b0 || cnt_a[0] !== 4'd0 || od_a[0] !== 5'sd0 || ordy_a[0] !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL flush_after got v=%b cnt=%0d d=%0d rdy=%b required 0 0 0 1",
                     ov_a[0], cnt_a[0], od_a[0], ordy_a[0]);
        end
        for (int s = 0; s < 6; s++) begin
            drive(1'b1, 1'b0, 5'sd0, 1'b1, 1'b0);
            checks = checks + 1;
            if (ov_a[0] !== 1'b0) begin
                failures = failures + 1;
                $display("FAIL flush_quiet s=%0d got v=%b required 0", s, ov_a[0]);
            end
        end
        for (int m = 0; m < 4; m++) drive(1'b1, 1'b1, 5'(m + 8), 1'b0, 1'b0);
        drive(1'b1, 1'b1, 5'sd5, 1'b0, 1'b1);
        checks = checks + 1;
        if (ordy_a[0] !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL flush_full_rdy got %b required 0", ordy_a[0]);
        end
        drain(8);
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 5'sd8, 1'b0, 1'b0);
        drive(1'b1, 1'b1, -5'sd9, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 5'sd11, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 5'sd0, 1'b1, 1'b0);
        checks = checks + 1;
        if (ov_a[0] !== 1'b0 || cnt_a[0] !== 4'd0 || od_a[0] !== 5'sd0 || ordy_a[0] !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL reset_mid got v=%b cnt=%0d d=%0d rdy=%b required 0 0 0 1",
                     ov_a[0], cnt_a[0], od_a[0], ordy_a[0]);
        end
        for (int s = 0; s < 8; s++) begin
            drive(1'b1, 1'b0, 5'sd0, 1'b1, 1'b0);
            checks = checks + 1;
            if (ov_a[0] !== 1'b0) begin
                failures = failures + 1;
                $display("FAIL reset_stale s=%0d got v=%b d=%0d required v=0", s, ov_a[0], od_a[0]);
            end
        end
    endtask

    task automatic test_random();
        int base [3];
        for (int g = 0; g < 3; g++) base[g] = emit_cnt[g];
        for (int n = 0; n < 1000; n++) begin
            drive(1'b1, 1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)),
                  1'($urandom_range(1, 0)), 1'($urandom_range(63, 0) == 0));
        end
        drain(10);
        for (int g = 0; g < 3; g++) begin
            checks = checks + 1;
            if (cnt_a[g] !== 4'd0 || ov_a[g] !== 1'b0 || (emit_cnt[g] - base[g]) < 100) begin
                failures = failures + 1;
                $display("FAIL random_end[%0d] got cnt=%0d v=%b outputs=%0d required 0 0 >=100",
                         g, cnt_a[g], ov_a[g], emit_cnt[g] - base[g]);
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0; mon_en = 1'b0;
        for (int g = 0; g < 3; g++) emit_cnt[g] = 0;
        rst = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_data = 5'sd0;
        test_reset();
        test_stream();
        test_stall();
        test_bubble();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipo_pipe.md
PIPO_PIPE -- requirements
Module: pipo_pipe

Interface
REQ-001 SHALL have parameter DW, default 5, signed data width in bits (DW >= 2).
REQ-002 SHALL have parameter DEPTH, default 4, number of register stages (DEPTH >= 1).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_flush  input  1  discard all stored data.
REQ-006 SHALL have port i_valid  input  1  upstream data valid.
REQ-007 SHALL have port o_ready  output  1  block accepts i_data this cycle.
REQ-008 SHALL have port i_data  input  DW  signed upstream data.
REQ-009 SHALL have port o_valid  output  1  o_data valid to downstream.
REQ-010 SHALL have port i_ready  input  1  downstream accepts o_data this cycle.
REQ-011 SHALL have port o_data  output  DW  signed data from last stage.
REQ-012 SHALL have port o_count  output  $clog2(DEPTH+1)  number of occupied stages.

Function
REQ-013 SHALL hold per stage k (0..DEPTH-1) one signed DW data register and one valid bit; stage 0 is input side, stage DEPTH-1 drives o_data/o_valid.
REQ-014 SHALL define stage k "can advance" when it is empty or stage k+1 can advance; for the last stage, when empty or i_ready=1.
REQ-015 SHALL drive o_ready = stage 0 can advance (combinational ready chain, full throughput, no bubble inserted).
REQ-016 SHALL transfer input on clk edge when i_valid=1 and o_ready=1 and i_flush=0; data stored bit-exact, no sign extension or truncation.
REQ-017 SHALL move stage k contents into stage k+1 on an edge where stage k is valid and stage k+1 can advance; stage k becomes empty unless refilled the same edge.
REQ-018 SHALL give latency DEPTH cycles from accepted input to o_valid=1 with i_ready held 1.
REQ-019 SHALL collapse bubbles: a valid stage advances into an empty downstream stage even while the output is stalled.
REQ-020 SHALL hold all stage data and valid bits unchanged while stalled (o_valid=1, i_ready=0, all stages full); o_data stable during stall.
REQ-021 SHALL, on an edge with i_flush=1, clear all valid bits and all data registers to 0; simultaneous input is dropped and simultaneous output handshake is still counted by downstream as completed.
REQ-022 SHALL keep o_ready independent of i_flush (flush does not backpressure).
REQ-023 SHALL update o_count registered, equal to the number of valid bits after each edge; range 0..DEPTH.
REQ-024 SHALL, with all stages full and i_ready=1, accept a new input and emit one output on the same edge (o_count stays DEPTH).
REQ-025 SHALL ignore i_data when i_valid=0; o_data when o_valid=0 is the last stage's register content (0 after reset/flush).

Reset
REQ-026 SHALL, on a clk edge with rst=0, clear all valid bits, all data registers and o_count to 0, overriding i_flush, i_valid and i_ready.
REQ-027 SHALL, after reset, present o_valid=0, o_data=0, o_count=0 and o_ready=1.
REQ-028 SHALL, on reset mid-operation, lose all in-flight data with no partial outputs on later cycles.

Structure
REQ-029 SHALL place default DW, default DEPTH and a count-width helper constant/function in shared package pipo_pkg.
REQ-030 SHALL implement each stage as sub-module pipe_stage (data+valid register with load/clear controls), instantiated DEPTH times by a generate loop.

Verification
REQ-031 Stream DW=5 DEPTH=4, i_ready=1, inputs -16,-1,0,15 on consecutive cycles -> o_data -16,-1,0,15 on cycles 4..7 after the first accept, o_valid=1 continuously.
REQ-032 Fill 4 values with i_ready=0 -> o_count=4, o_ready=0, o_data = first value stable; raise i_ready -> one output per cycle, o_ready=1 same cycle.
REQ-033 Input 7, one idle cycle, then 3, with output stalled -> bubble collapses, o_count=2, outputs 7 then 3 with no gap once i_ready=1.
REQ-034 Pipeline holding 3 values, assert i_flush with i_valid=1 data 5 -> next cycle o_valid=0, o_count=0, o_data=0, value 5 never appears.
REQ-035 Assert rst=0 for one edge while 2 values in flight and i_valid=1 -> o_valid=0, o_count=0, o_data=0, o_ready=1; no stale value emerges in the following 8 cycles.
REQ-036 Random i_valid/i_ready, 1000 cycles, DEPTH=1 and DEPTH=6 -> output sequence equals accepted input sequence in order, o_count matches scoreboard every cycle.
